// File: rtl/prc_pkg.sv
// Shared constants and types for the LCD frame-copy path. The scan-out side
// reads the same geometry constants.
package prc_pkg;

  localparam int          LCD_PAGES = 8;
  localparam int          LCD_COLS  = 96;
  localparam int          FB_BYTES  = LCD_PAGES * LCD_COLS;
  localparam logic [12:0] FB_BASE   = 13'h1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_COPY  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } prc_state_t;

endpackage

// File: rtl/prc_addr_gen.sv
// Page/column walker for the framebuffer copy. The linear offset is kept as
// its own counter so no multiplier is needed to form page*COLS+col.
module prc_addr_gen
  import prc_pkg::*;
#(
  parameter int PAGES = LCD_PAGES,
  parameter int COLS  = LCD_COLS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        adv,
  output logic [2:0]  page,
  output logic [6:0]  col,
  output logic [12:0] offset,
  output logic        last
);

  localparam logic [2:0] PAGE_MAX = 3'(PAGES - 1);
  localparam logic [6:0] COL_MAX  = 7'(COLS - 1);

  // Step one byte per accepted read; clear returns to page 0, column 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      page   <= '0;
      col    <= '0;
      offset <= '0;
    end else if (clr) begin
      page   <= '0;
      col    <= '0;
      offset <= '0;
    end else if (adv) begin
      offset <= offset + 13'd1;
      if (col == COL_MAX) begin
        col  <= '0;
        page <= page + 3'd1;
      end else begin
        col <= col + 7'd1;
      end
    end
  end

  assign last = (page == PAGE_MAX) && (col == COL_MAX);

endmodule

// File: rtl/prc_copy.sv
// Frame-copy engine: on start, owns the system bus and streams the
// 768-byte framebuffer from system RAM into LCD display RAM, one byte/cycle
// while granted. Reads are combinational on grant; the write lands one
// cycle later when the synchronous RAM data arrives.
module prc_copy
  import prc_pkg::*;
#(
  parameter logic [12:0] SRC_BASE = FB_BASE,
  parameter int          PAGES    = LCD_PAGES,
  parameter int          COLS     = LCD_COLS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [12:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  output logic [2:0]  lcd_page,
  output logic [6:0]  lcd_col,
  output logic [7:0]  lcd_data,
  output logic        lcd_we,
  output logic        busy,
  output logic        frame_complete
);

  prc_state_t  state, state_nxt;
  logic        abort, abort_nxt;
  logic        rd_go;
  logic [2:0]  ag_page;
  logic [6:0]  ag_col;
  logic [12:0] ag_offset;
  logic        ag_last;

  // A read goes out only while copying, granted and still enabled.
  assign rd_go = (state == ST_COPY) && bus_grant && enable;

  prc_addr_gen #(
    .PAGES (PAGES),
    .COLS  (COLS)
  ) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == ST_IDLE),
    .adv     (rd_go),
    .page    (ag_page),
    .col     (ag_col),
    .offset  (ag_offset),
    .last    (ag_last)
  );

  // Next-state logic; losing enable funnels through DRAIN so an in-flight
  // write still completes, then returns to IDLE without a completion pulse.
  always_comb begin
    state_nxt = state;
    abort_nxt = abort;
    case (state)
      ST_IDLE: begin
        abort_nxt = 1'b0;
        if (start && enable) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!enable) begin
          state_nxt = ST_DRAIN;
          abort_nxt = 1'b1;
        end else if (bus_grant) begin
          state_nxt = ST_COPY;
        end
      end
      ST_COPY: begin
        if (!enable) begin
          state_nxt = ST_DRAIN;
          abort_nxt = 1'b1;
        end else if (rd_go && ag_last) begin
          state_nxt = ST_DRAIN;
        end
      end
      // Wait for the write pipeline to empty before leaving.
      ST_DRAIN: begin
        if (!lcd_we) state_nxt = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State and abort flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      abort <= 1'b0;
    end else begin
      state <= state_nxt;
      abort <= abort_nxt;
    end
  end

  // Write stage: capture the LCD address alongside each issued read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_we   <= 1'b0;
      lcd_page <= '0;
      lcd_col  <= '0;
    end else begin
      lcd_we <= rd_go;
      if (rd_go) begin
        lcd_page <= ag_page;
        lcd_col  <= ag_col;
      end
    end
  end

  assign src_rd         = rd_go;
  assign src_addr       = rd_go ? (SRC_BASE + ag_offset) : '0;
  assign lcd_data       = lcd_we ? src_data : '0;
  assign bus_req        = (state == ST_REQ) || (state == ST_COPY) ||
                          ((state == ST_DRAIN) && !abort);
  assign busy           = (state != ST_IDLE);
  assign frame_complete = (state == ST_DONE);

endmodule

// File: tb/tb_prc_copy.sv
// Bench for prc_copy: a byte-addressed RAM model feeds the engine; the
// reference is the linear framebuffer order (k-th byte -> page k/96,
// col k%96, address 0x1000+k) checked on every read and write.
module tb_prc_copy;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        bus_grant = 1'b0;
  logic        bus_req, src_rd, lcd_we, busy, frame_complete;
  logic [12:0] src_addr;
  logic [7:0]  src_data = 8'h00;
  logic [7:0]  lcd_data;
  logic [2:0]  lcd_page;
  logic [6:0]  lcd_col;

  logic [7:0]  mem [0:8191];

  int n_chk = 0, n_bad = 0;
  int gmode = 0;
  int cyc = 0, t0 = 0;
  int rd_idx, wr_idx, fc_cnt, fc_at, first_we;
  int err_data, err_addr, err_misc;
  bit en_next = 1'b1;
  bit start_rec = 1'b0;

  always #5 clk = ~clk;

  // Synchronous system RAM, one-cycle read latency.
  always @(posedge clk) if (src_rd) src_data <= mem[src_addr];

  prc_copy dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .start          (start),
    .bus_req        (bus_req),
    .bus_grant      (bus_grant),
    .src_addr       (src_addr),
    .src_rd         (src_rd),
    .src_data       (src_data),
    .lcd_page       (lcd_page),
    .lcd_col        (lcd_col),
    .lcd_data       (lcd_data),
    .lcd_we         (lcd_we),
    .busy           (busy),
    .frame_complete (frame_complete)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    rd_idx = 0; wr_idx = 0; fc_cnt = 0; fc_at = -1; first_we = -1;
    err_data = 0; err_addr = 0; err_misc = 0;
  endtask

  // One clock: drive inputs just after the edge, sample at the falling edge.
  task automatic tick();
    int k;
    @(posedge clk);
    cyc++;
    if (start_rec) begin t0 = cyc; start_rec = 1'b0; end
    #1;
    start  = 1'b0;
    enable = en_next;
    case (gmode)
      0:       bus_grant = 1'b1;
      1:       bus_grant = ~bus_grant;
      2:       bus_grant = ((cyc - t0) > 20);
      default: bus_grant = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    k = cyc - t0;
    if (src_rd) begin
      if (src_addr !== 13'(32'h1000 + rd_idx)) err_addr++;
      if (!bus_grant || !bus_req) err_misc++;
      rd_idx++;
    end
    if (lcd_we) begin
      if (first_we < 0) first_we = k;
      if (!busy || wr_idx >= 768) err_misc++;
      else if (lcd_page !== 3'(wr_idx / 96) || lcd_col !== 7'(wr_idx % 96) ||
               lcd_data !== mem[32'h1000 + wr_idx]) err_data++;
      wr_idx++;
    end
    if (frame_complete) begin fc_cnt++; fc_at = k; end
    if (gmode == 2 && busy && k <= 20 && (!bus_req || src_rd)) err_misc++;
  endtask

  task automatic fill_mem(input bit pattern);
    for (int i = 0; i < 8192; i++)
      mem[i] = pattern ? 8'(i - 32'h1000) : 8'($urandom);
  endtask

  // Pulse start (sampled at the next edge, which becomes edge 0).
  task automatic kick();
    clr_mon();
    en_next = 1'b1;
    enable = 1'b1;
    start = 1'b1;
    start_rec = 1'b1;
    tick();
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) chk({tag, "_timeout"}, 1, 0);
    repeat (3) tick();
  endtask

  task automatic chk_full(input string tag);
    chk({tag, "_writes"}, wr_idx, 768);
    chk({tag, "_reads"}, rd_idx, 768);
    chk({tag, "_data"}, err_data, 0);
    chk({tag, "_addr"}, err_addr, 0);
    chk({tag, "_misc"}, err_misc, 0);
    chk({tag, "_fc_cnt"}, fc_cnt, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_outs", {bus_req, src_rd, lcd_we, busy, frame_complete,
                     src_addr, lcd_data, lcd_page, lcd_col}, 0);
    reset_n = 1'b1;
    enable = 1'b1;
    tick();

    // start while disabled is ignored
    en_next = 1'b0; enable = 1'b0; start = 1'b1; tick(); tick();
    chk("start_dis_busy", busy, 0);

    // Grant tied high, pattern data, exact latency
    fill_mem(1'b1);
    gmode = 0;
    kick();
    chk("req_after_start", bus_req, 1);
    chk("busy_after_start", busy, 1);
    run_to_idle("t1", 2000);
    chk_full("t1");
    chk("t1_first_we", first_we, 2);
    chk("t1_fc_at", fc_at, 771);

    // Grant toggling every cycle
    fill_mem(1'b0);
    gmode = 1;
    kick();
    run_to_idle("t2", 4000);
    chk_full("t2");
    chk("t2_fc_window", (fc_at >= 1534 && fc_at <= 1542), 1);

    // Grant withheld for 20 cycles
    fill_mem(1'b0);
    gmode = 2;
    kick();
    run_to_idle("t3", 2000);
    chk_full("t3");
    chk("t3_fc_at", fc_at, 792);

    // start re-pulsed mid-copy
    gmode = 0;
    kick();
    for (int i = 0; i < 99; i++) tick();
    start = 1'b1;
    run_to_idle("t4", 2000);
    repeat (5) tick();
    chk_full("t4");
    chk("t4_idle", busy, 0);

    // enable dropped after the 300th read, random grant
    fill_mem(1'b0);
    gmode = 3;
    kick();
    for (int i = 0; i < 3000 && rd_idx < 300; i++) tick();
    en_next = 1'b0;
    run_to_idle("t5", 100);
    chk("t5_reads", rd_idx, 300);
    chk("t5_writes", wr_idx, 300);
    chk("t5_data", err_data, 0);
    chk("t5_fc_cnt", fc_cnt, 0);
    chk("t5_bus_req", bus_req, 0);
    chk("t5_busy", busy, 0);

    // Asynchronous reset mid-copy, then a clean copy from the start
    gmode = 0;
    kick();
    repeat (50) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_outs", {bus_req, src_rd, lcd_we, busy, frame_complete,
                          src_addr, lcd_data, lcd_page, lcd_col}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    fill_mem(1'b0);
    kick();
    run_to_idle("t6", 2000);
    chk_full("t6");
    chk("t6_fc_at", fc_at, 771);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
